// File: rtl/mc_arb_pkg.sv
// Shared definitions for the MC port arbiter: MC command encodings,
// MC field widths and a constant-evaluable clog2 helper.
package mc_arb_pkg;

    localparam logic [2:0] MC_CMD_RD = 3'd1;
    localparam logic [2:0] MC_CMD_WR = 3'd2;

    localparam int MC_CMD_W  = 3;
    localparam int MC_SCMD_W = 4;
    localparam int MC_VADR_W = 48;
    localparam int MC_SIZE_W = 2;
    localparam int MC_DATA_W = 64;
    localparam int PERF_W    = 32;

    // Ceiling log2; clog2(1) = 0 so a single-requester build still elaborates
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mc_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or above the
// rotating pointer (modulo NUM_REQ) and advances the pointer past the winner.
module rr_arbiter
    import mc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_vld
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_found;
    int                 w_idx;

    // Scan requesters starting at the pointer, wrapping at NUM_REQ, first hit wins
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && i_en && i_req[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_grant_id     = ID_W'(w_idx);
            end
        end
    end

    // Pointer moves to one past the winner on a grant, otherwise holds
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            if (int'(w_grant_id) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_id + ID_W'(1);
            end
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_id  = w_grant_id;
    assign o_grant_vld = w_found;

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one MC request/response port between NUM_REQ requesters.
// Requests are round-robin arbitrated and registered once toward the MC with
// the requester ID prepended to rtnctl; responses are routed back by that ID.
// Optional performance counters are built when MC_ARB_PERF_EN is defined.
module mc_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int RTNCTL_WIDTH = 32,
    parameter int ID_W         = clog2(NUM_REQ),
    localparam int TW          = RTNCTL_WIDTH - ID_W
) (
    input  logic                           clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [MC_CMD_W*NUM_REQ-1:0]    i_req_cmd,
    input  logic [MC_SCMD_W*NUM_REQ-1:0]   i_req_scmd,
    input  logic [MC_VADR_W*NUM_REQ-1:0]   i_req_vadr,
    input  logic [MC_SIZE_W*NUM_REQ-1:0]   i_req_size,
    input  logic [MC_DATA_W*NUM_REQ-1:0]   i_req_data,
    input  logic [TW*NUM_REQ-1:0]          i_req_rtnctl,
    output logic [NUM_REQ-1:0]             o_req_stall,
    output logic [NUM_REQ-1:0]             o_rsp_vld,
    output logic [MC_CMD_W-1:0]            o_rsp_cmd,
    output logic [MC_SCMD_W-1:0]           o_rsp_scmd,
    output logic [MC_DATA_W-1:0]           o_rsp_data,
    output logic [TW-1:0]                  o_rsp_rtnctl,
    input  logic [NUM_REQ-1:0]             i_rsp_stall,
    output logic                           o_mc_rq_vld,
    output logic [MC_CMD_W-1:0]            o_mc_rq_cmd,
    output logic [MC_SCMD_W-1:0]           o_mc_rq_scmd,
    output logic [MC_VADR_W-1:0]           o_mc_rq_vadr,
    output logic [MC_SIZE_W-1:0]           o_mc_rq_size,
    output logic [MC_DATA_W-1:0]           o_mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]        o_mc_rq_rtnctl,
    input  logic                           i_mc_rq_stall,
    input  logic                           i_mc_rs_vld,
    input  logic [MC_CMD_W-1:0]            i_mc_rs_cmd,
    input  logic [MC_SCMD_W-1:0]           i_mc_rs_scmd,
    input  logic [MC_DATA_W-1:0]           i_mc_rs_data,
    input  logic [RTNCTL_WIDTH-1:0]        i_mc_rs_rtnctl,
    output logic                           o_mc_rs_stall,
`ifdef MC_ARB_PERF_EN
    input  logic                           i_perf_clr,
    output logic [PERF_W*NUM_REQ-1:0]      o_perf_grant_cnt,
    output logic [PERF_W-1:0]              o_perf_stall_cyc,
`endif
    output logic                           o_err_bad_id
);

    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_grant_id;
    logic                    w_grant_vld;
    logic                    w_arb_en;

    logic [MC_CMD_W-1:0]     w_sel_cmd;
    logic [MC_SCMD_W-1:0]    w_sel_scmd;
    logic [MC_VADR_W-1:0]    w_sel_vadr;
    logic [MC_SIZE_W-1:0]    w_sel_size;
    logic [MC_DATA_W-1:0]    w_sel_data;
    logic [TW-1:0]           w_sel_rtnctl;

    logic                    r_mc_rq_vld;
    logic [MC_CMD_W-1:0]     r_mc_rq_cmd;
    logic [MC_SCMD_W-1:0]    r_mc_rq_scmd;
    logic [MC_VADR_W-1:0]    r_mc_rq_vadr;
    logic [MC_SIZE_W-1:0]    r_mc_rq_size;
    logic [MC_DATA_W-1:0]    r_mc_rq_data;
    logic [RTNCTL_WIDTH-1:0] r_mc_rq_rtnctl;

    logic [ID_W-1:0]         w_rs_id;
    logic                    w_rs_id_ok;
    logic [NUM_REQ-1:0]      w_rs_onehot;

    logic [NUM_REQ-1:0]      r_rsp_vld;
    logic [MC_CMD_W-1:0]     r_rsp_cmd;
    logic [MC_SCMD_W-1:0]    r_rsp_scmd;
    logic [MC_DATA_W-1:0]    r_rsp_data;
    logic [TW-1:0]           r_rsp_rtnctl;
    logic                    r_mc_rs_stall;
    logic                    r_err_bad_id;

    // MC backpressure and reset both suppress any grant in the current cycle
    assign w_arb_en = ~i_mc_rq_stall & ~i_reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_req       (i_req_vld),
        .i_en        (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_grant_vld (w_grant_vld)
    );

    assign o_req_stall = ~w_grant;

    // Pick the winning requester's fields out of the flattened request buses
    always_comb begin
        w_sel_cmd    = i_req_cmd   [int'(w_grant_id)*MC_CMD_W  +: MC_CMD_W];
        w_sel_scmd   = i_req_scmd  [int'(w_grant_id)*MC_SCMD_W +: MC_SCMD_W];
        w_sel_vadr   = i_req_vadr  [int'(w_grant_id)*MC_VADR_W +: MC_VADR_W];
        w_sel_size   = i_req_size  [int'(w_grant_id)*MC_SIZE_W +: MC_SIZE_W];
        w_sel_data   = i_req_data  [int'(w_grant_id)*MC_DATA_W +: MC_DATA_W];
        w_sel_rtnctl = i_req_rtnctl[int'(w_grant_id)*TW        +: TW];
    end

    // Single register stage toward the MC; valid pulses once per accepted request
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_mc_rq_vld    <= 1'b0;
            r_mc_rq_cmd    <= '0;
            r_mc_rq_scmd   <= '0;
            r_mc_rq_vadr   <= '0;
            r_mc_rq_size   <= '0;
            r_mc_rq_data   <= '0;
            r_mc_rq_rtnctl <= '0;
        end else begin
            r_mc_rq_vld <= w_grant_vld;
            if (w_grant_vld) begin
                r_mc_rq_cmd    <= w_sel_cmd;
                r_mc_rq_scmd   <= w_sel_scmd;
                r_mc_rq_vadr   <= w_sel_vadr;
                r_mc_rq_size   <= w_sel_size;
                r_mc_rq_data   <= w_sel_data;
                r_mc_rq_rtnctl <= {w_grant_id, w_sel_rtnctl};
            end
        end
    end

    assign w_rs_id    = i_mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];
    assign w_rs_id_ok = (int'(w_rs_id) < NUM_REQ);

    // Decode the response ID into a one-hot; out-of-range IDs decode to nothing
    always_comb begin
        w_rs_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rs_onehot[i] = i_mc_rs_vld && (int'(w_rs_id) == i);
        end
    end

    // Register routed responses and latch a sticky error on a bad ID
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rsp_vld    <= '0;
            r_rsp_cmd    <= '0;
            r_rsp_scmd   <= '0;
            r_rsp_data   <= '0;
            r_rsp_rtnctl <= '0;
            r_err_bad_id <= 1'b0;
        end else begin
            r_rsp_vld <= w_rs_onehot;
            if (i_mc_rs_vld && w_rs_id_ok) begin
                r_rsp_cmd    <= i_mc_rs_cmd;
                r_rsp_scmd   <= i_mc_rs_scmd;
                r_rsp_data   <= i_mc_rs_data;
                r_rsp_rtnctl <= i_mc_rs_rtnctl[TW-1:0];
            end
            if (i_mc_rs_vld && !w_rs_id_ok) begin
                r_err_bad_id <= 1'b1;
            end
        end
    end

    // Any requester stalling backpressures the MC one cycle later
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_mc_rs_stall <= 1'b0;
        end else begin
            r_mc_rs_stall <= |i_rsp_stall;
        end
    end

`ifdef MC_ARB_PERF_EN
    logic [PERF_W*NUM_REQ-1:0] r_perf_grant_cnt;
    logic [PERF_W-1:0]         r_perf_stall_cyc;

    // Saturating per-requester accept counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (i_reset || i_perf_clr) begin
            r_perf_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && (r_perf_grant_cnt[i*PERF_W +: PERF_W] != '1)) begin
                    r_perf_grant_cnt[i*PERF_W +: PERF_W] <= r_perf_grant_cnt[i*PERF_W +: PERF_W] + PERF_W'(1);
                end
            end
        end
    end

    // Saturating count of cycles where requests wait on MC backpressure
    always_ff @(posedge clk) begin
        if (i_reset || i_perf_clr) begin
            r_perf_stall_cyc <= '0;
        end else if ((|i_req_vld) && i_mc_rq_stall && (r_perf_stall_cyc != '1)) begin
            r_perf_stall_cyc <= r_perf_stall_cyc + PERF_W'(1);
        end
    end

    assign o_perf_grant_cnt = r_perf_grant_cnt;
    assign o_perf_stall_cyc = r_perf_stall_cyc;
`else
`endif

    assign o_mc_rq_vld    = r_mc_rq_vld;
    assign o_mc_rq_cmd    = r_mc_rq_cmd;
    assign o_mc_rq_scmd   = r_mc_rq_scmd;
    assign o_mc_rq_vadr   = r_mc_rq_vadr;
    assign o_mc_rq_size   = r_mc_rq_size;
    assign o_mc_rq_data   = r_mc_rq_data;
    assign o_mc_rq_rtnctl = r_mc_rq_rtnctl;

    assign o_rsp_vld      = r_rsp_vld;
    assign o_rsp_cmd      = r_rsp_cmd;
    assign o_rsp_scmd     = r_rsp_scmd;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_rtnctl   = r_rsp_rtnctl;

    assign o_mc_rs_stall  = r_mc_rs_stall;
    assign o_err_bad_id   = r_err_bad_id;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter: a 4-requester instance for arbitration,
// request pipeline and routing, plus a 3-requester instance for bad-ID handling.
// Perf counter steps are built when MC_ARB_PERF_EN is defined.
module tb_mc_port_arbiter;
    import mc_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int BREQ = 3;
    localparam int RW   = 32;
    localparam int TW   = 30;

    logic clk = 1'b0;
    logic reset;

    logic [NREQ-1:0]    reqVld;
    logic [3*NREQ-1:0]  reqCmd;
    logic [4*NREQ-1:0]  reqScmd;
    logic [48*NREQ-1:0] reqVadr;
    logic [2*NREQ-1:0]  reqSize;
    logic [64*NREQ-1:0] reqData;
    logic [TW*NREQ-1:0] reqRtnctl;
    logic [NREQ-1:0]    reqStall;
    logic [NREQ-1:0]    rspVld;
    logic [2:0]         rspCmd;
    logic [3:0]         rspScmd;
    logic [63:0]        rspData;
    logic [TW-1:0]      rspRtnctl;
    logic [NREQ-1:0]    rspStall;
    logic               mcRqVld;
    logic [2:0]         mcRqCmd;
    logic [3:0]         mcRqScmd;
    logic [47:0]        mcRqVadr;
    logic [1:0]         mcRqSize;
    logic [63:0]        mcRqData;
    logic [RW-1:0]      mcRqRtnctl;
    logic               mcRqStall;
    logic               mcRsVld;
    logic [2:0]         mcRsCmd;
    logic [3:0]         mcRsScmd;
    logic [63:0]        mcRsData;
    logic [RW-1:0]      mcRsRtnctl;
    logic               mcRsStall;
    logic               errBadId;

    logic [BREQ-1:0]    bReqVld;
    logic [3*BREQ-1:0]  bReqCmd;
    logic [4*BREQ-1:0]  bReqScmd;
    logic [48*BREQ-1:0] bReqVadr;
    logic [2*BREQ-1:0]  bReqSize;
    logic [64*BREQ-1:0] bReqData;
    logic [TW*BREQ-1:0] bReqRtnctl;
    logic [BREQ-1:0]    bReqStall;
    logic [BREQ-1:0]    bRspVld;
    logic [2:0]         bRspCmd;
    logic [3:0]         bRspScmd;
    logic [63:0]        bRspData;
    logic [TW-1:0]      bRspRtnctl;
    logic [BREQ-1:0]    bRspStall;
    logic               bMcRqVld;
    logic [2:0]         bMcRqCmd;
    logic [3:0]         bMcRqScmd;
    logic [47:0]        bMcRqVadr;
    logic [1:0]         bMcRqSize;
    logic [63:0]        bMcRqData;
    logic [RW-1:0]      bMcRqRtnctl;
    logic               bMcRsStall;
    logic               bErrBadId;

`ifdef MC_ARB_PERF_EN
    logic               perfClr;
    logic [32*NREQ-1:0] perfGrantCnt;
    logic [31:0]        perfStallCyc;
    logic [32*BREQ-1:0] bPerfGrantCnt;
    logic [31:0]        bPerfStallCyc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_port_arbiter #(.NUM_REQ(NREQ), .RTNCTL_WIDTH(RW), .ID_W(2)) dutA (
        .clk(clk), .i_reset(reset),
        .i_req_vld(reqVld), .i_req_cmd(reqCmd), .i_req_scmd(reqScmd),
        .i_req_vadr(reqVadr), .i_req_size(reqSize), .i_req_data(reqData),
        .i_req_rtnctl(reqRtnctl), .o_req_stall(reqStall),
        .o_rsp_vld(rspVld), .o_rsp_cmd(rspCmd), .o_rsp_scmd(rspScmd),
        .o_rsp_data(rspData), .o_rsp_rtnctl(rspRtnctl), .i_rsp_stall(rspStall),
        .o_mc_rq_vld(mcRqVld), .o_mc_rq_cmd(mcRqCmd), .o_mc_rq_scmd(mcRqScmd),
        .o_mc_rq_vadr(mcRqVadr), .o_mc_rq_size(mcRqSize), .o_mc_rq_data(mcRqData),
        .o_mc_rq_rtnctl(mcRqRtnctl), .i_mc_rq_stall(mcRqStall),
        .i_mc_rs_vld(mcRsVld), .i_mc_rs_cmd(mcRsCmd), .i_mc_rs_scmd(mcRsScmd),
        .i_mc_rs_data(mcRsData), .i_mc_rs_rtnctl(mcRsRtnctl),
        .o_mc_rs_stall(mcRsStall),
`ifdef MC_ARB_PERF_EN
        .i_perf_clr(perfClr), .o_perf_grant_cnt(perfGrantCnt),
        .o_perf_stall_cyc(perfStallCyc),
`endif
        .o_err_bad_id(errBadId)
    );

    mc_port_arbiter #(.NUM_REQ(BREQ), .RTNCTL_WIDTH(RW), .ID_W(2)) dutB (
        .clk(clk), .i_reset(reset),
        .i_req_vld(bReqVld), .i_req_cmd(bReqCmd), .i_req_scmd(bReqScmd),
        .i_req_vadr(bReqVadr), .i_req_size(bReqSize), .i_req_data(bReqData),
        .i_req_rtnctl(bReqRtnctl), .o_req_stall(bReqStall),
        .o_rsp_vld(bRspVld), .o_rsp_cmd(bRspCmd), .o_rsp_scmd(bRspScmd),
        .o_rsp_data(bRspData), .o_rsp_rtnctl(bRspRtnctl), .i_rsp_stall(bRspStall),
        .o_mc_rq_vld(bMcRqVld), .o_mc_rq_cmd(bMcRqCmd), .o_mc_rq_scmd(bMcRqScmd),
        .o_mc_rq_vadr(bMcRqVadr), .o_mc_rq_size(bMcRqSize), .o_mc_rq_data(bMcRqData),
        .o_mc_rq_rtnctl(bMcRqRtnctl), .i_mc_rq_stall(1'b0),
        .i_mc_rs_vld(mcRsVld), .i_mc_rs_cmd(mcRsCmd), .i_mc_rs_scmd(mcRsScmd),
        .i_mc_rs_data(mcRsData), .i_mc_rs_rtnctl(mcRsRtnctl),
        .o_mc_rs_stall(bMcRsStall),
`ifdef MC_ARB_PERF_EN
        .i_perf_clr(perfClr), .o_perf_grant_cnt(bPerfGrantCnt),
        .o_perf_stall_cyc(bPerfStallCyc),
`endif
        .o_err_bad_id(bErrBadId)
    );

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the request valids and MC backpressure for the coming cycle
    task automatic applyStimulus(input logic [NREQ-1:0] vld, input logic stall);
        reqVld    = vld;
        mcRqStall = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        logic [NREQ-1:0] grantSeen;
        logic [NREQ-1:0] expGrant;
        int pulses;

        reset      = 1'b1;
        reqVld     = '0;
        mcRqStall  = 1'b0;
        rspStall   = '0;
        mcRsVld    = 1'b0;
        mcRsCmd    = '0;
        mcRsScmd   = '0;
        mcRsData   = '0;
        mcRsRtnctl = '0;
        reqScmd    = '0;
        reqSize    = '0;
        reqData    = '0;
        bReqVld    = '0;
        bReqCmd    = '0;
        bReqScmd   = '0;
        bReqVadr   = '0;
        bReqSize   = '0;
        bReqData   = '0;
        bReqRtnctl = '0;
        bRspStall  = '0;
`ifdef MC_ARB_PERF_EN
        perfClr    = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            reqCmd[i*3 +: 3]     = MC_CMD_RD;
            reqVadr[i*48 +: 48]  = 48'(32'h100 * (i + 1));
            reqRtnctl[i*TW +: TW] = TW'(32'h10 + i);
            reqData[i*64 +: 64]  = 64'(32'hA0 + i);
        end

        // Reset state, with requests asserted to prove reset blocks grants
        applyStimulus(4'hF, 1'b0);
        tick();
        tick();
        checkOutput("reset_req_stall", 64'(reqStall), 64'hF);
        checkOutput("reset_mc_rq_vld", 64'(mcRqVld), 64'h0);
        checkOutput("reset_rsp_vld", 64'(rspVld), 64'h0);
        checkOutput("reset_mc_rs_stall", 64'(mcRsStall), 64'h0);
        checkOutput("reset_err_bad_id", 64'(errBadId), 64'h0);
        applyStimulus(4'h0, 1'b0);
        reset = 1'b0;

        // Single request from requester 2
        reqVadr[2*48 +: 48]   = 48'h1000;
        reqRtnctl[2*TW +: TW] = TW'(5);
        applyStimulus(4'b0100, 1'b0);
        settle();
        checkOutput("t1_req_stall", 64'(reqStall), 64'hB);
        tick();
        applyStimulus(4'h0, 1'b0);
        checkOutput("t1_mc_rq_vld", 64'(mcRqVld), 64'h1);
        checkOutput("t1_mc_rq_cmd", 64'(mcRqCmd), 64'(MC_CMD_RD));
        checkOutput("t1_mc_rq_vadr", 64'(mcRqVadr), 64'h1000);
        checkOutput("t1_mc_rq_rtnctl", 64'(mcRqRtnctl), 64'h8000_0005);
        checkOutput("t1_mc_rq_data", 64'(mcRqData), 64'hA2);
        tick();
        checkOutput("t1_mc_rq_vld_drop", 64'(mcRqVld), 64'h0);

        // All four requesting for eight cycles: strict rotation from 0
        doReset();
        applyStimulus(4'hF, 1'b0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            settle();
            grantSeen = ~reqStall;
            expGrant  = NREQ'(1 << (k % 4));
            checkOutput("t2_grant", 64'(grantSeen), 64'(expGrant));
            tick();
            checkOutput("t2_rq_id", 64'(mcRqRtnctl[31:30]), 64'(k % 4));
            if (mcRqVld === 1'b1) pulses++;
        end
        applyStimulus(4'h0, 1'b0);
        checkOutput("t2_pulses", 64'(pulses), 64'd8);
        tick();
        checkOutput("t2_idle", 64'(mcRqVld), 64'h0);

        // MC backpressure after grant 1: in-flight request issues, then resume at 2
        doReset();
        applyStimulus(4'hF, 1'b0);
        settle();
        checkOutput("t3_grant0", 64'(reqStall), 64'hE);
        tick();
        settle();
        checkOutput("t3_grant1", 64'(reqStall), 64'hD);
        tick();
        applyStimulus(4'hF, 1'b1);
        settle();
        checkOutput("t3_inflight_vld", 64'(mcRqVld), 64'h1);
        checkOutput("t3_inflight_id", 64'(mcRqRtnctl[31:30]), 64'd1);
        for (int j = 0; j < 5; j++) begin
            checkOutput("t3_stall_all", 64'(reqStall), 64'hF);
            tick();
            settle();
            checkOutput("t3_no_issue", 64'(mcRqVld), 64'h0);
        end
        applyStimulus(4'hF, 1'b0);
        settle();
        checkOutput("t3_resume_grant", 64'(reqStall), 64'hB);
        tick();
        applyStimulus(4'h0, 1'b0);
        checkOutput("t3_resume_vld", 64'(mcRqVld), 64'h1);
        checkOutput("t3_resume_id", 64'(mcRqRtnctl[31:30]), 64'd2);
        tick();

        // Responses: ID 3 routes on the 4-way instance, is a bad ID on the 3-way one
        mcRsVld    = 1'b1;
        mcRsCmd    = 3'd2;
        mcRsScmd   = 4'h0;
        mcRsData   = 64'hDEAD;
        mcRsRtnctl = 32'hC000_002A;
        tick();
        checkOutput("t4_rsp_vld", 64'(rspVld), 64'h8);
        checkOutput("t4_rsp_rtnctl", 64'(rspRtnctl), 64'h2A);
        checkOutput("t4_rsp_data", 64'(rspData), 64'hDEAD);
        checkOutput("t4_rsp_cmd", 64'(rspCmd), 64'd2);
        checkOutput("t4_err_ok", 64'(errBadId), 64'h0);
        checkOutput("t4b_rsp_vld", 64'(bRspVld), 64'h0);
        checkOutput("t4b_err_bad_id", 64'(bErrBadId), 64'h1);
        mcRsData   = 64'hBEEF;
        mcRsRtnctl = 32'h0000_0001;
        tick();
        mcRsVld = 1'b0;
        checkOutput("t4_rsp_vld_id0", 64'(rspVld), 64'h1);
        checkOutput("t4_rsp_rtnctl_id0", 64'(rspRtnctl), 64'h1);
        checkOutput("t4_rsp_data_id0", 64'(rspData), 64'hBEEF);
        checkOutput("t4b_rsp_vld_id0", 64'(bRspVld), 64'h1);
        checkOutput("t4b_err_sticky", 64'(bErrBadId), 64'h1);
        tick();
        checkOutput("t4_rsp_vld_drop", 64'(rspVld), 64'h0);

        // Response backpressure lags one cycle
        rspStall = 4'b0010;
        settle();
        checkOutput("t5_rs_stall_lag", 64'(mcRsStall), 64'h0);
        tick();
        checkOutput("t5_rs_stall_set", 64'(mcRsStall), 64'h1);
        rspStall = 4'b0000;
        tick();
        checkOutput("t5_rs_stall_clr", 64'(mcRsStall), 64'h0);

        // Reset mid-burst clears the pipeline, pointer and sticky error
        applyStimulus(4'hF, 1'b0);
        tick();
        tick();
        checkOutput("t5_burst_vld", 64'(mcRqVld), 64'h1);
        reset = 1'b1;
        tick();
        checkOutput("t5_rst_mc_rq_vld", 64'(mcRqVld), 64'h0);
        checkOutput("t5_rst_err", 64'(bErrBadId), 64'h0);
        checkOutput("t5_rst_req_stall", 64'(reqStall), 64'hF);
        reset = 1'b0;
        settle();
        checkOutput("t5_ptr_zero", 64'(reqStall), 64'hE);
        tick();
        applyStimulus(4'h0, 1'b0);
        checkOutput("t5_first_id", 64'(mcRqRtnctl[31:30]), 64'd0);
        tick();

`ifdef MC_ARB_PERF_EN
        // Perf: three accepts by requester 0, then a clear
        doReset();
        applyStimulus(4'b0001, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(4'h0, 1'b0);
        checkOutput("t6_grant_cnt", 64'(perfGrantCnt[31:0]), 64'd3);
        checkOutput("t6_grant_cnt1", 64'(perfGrantCnt[63:32]), 64'd0);
        perfClr = 1'b1;
        tick();
        perfClr = 1'b0;
        checkOutput("t6_grant_cnt_clr", 64'(perfGrantCnt[31:0]), 64'd0);
        applyStimulus(4'h3, 1'b1);
        tick();
        tick();
        applyStimulus(4'h0, 1'b0);
        checkOutput("t6_stall_cyc", 64'(perfStallCyc), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
